// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - lap-count sequencer owning the counter's clear and enable
// Optional feature macro: CNT_SEQ_HOLD_EN (adds the hold input that pauses a run).
// Moore FSM IDLE -> CLEAR -> RUN -> DONE -> IDLE. One lap is counted on each
// rco seen in RUN, and laps_left is decremented on that lap.

module counter_seq_ctrl #(
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LAP_W-1:0] laps,
  input  logic             abort,
  input  logic             rco,
`ifdef CNT_SEQ_HOLD_EN
  input  logic             hold,
`endif
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] laps_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LAP_W-1:0] laps_left_q, laps_left_d;
  logic             hold_w;

  // A held run freezes both the lap count and the counter enable.
`ifdef CNT_SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // State and remaining-lap registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      laps_left_q <= '0;
    end else begin
      state_q     <= state_d;
      laps_left_q <= laps_left_d;
    end
  end

  // Next-state and lap bookkeeping; abort beats a coincident rco.
  always_comb begin
    state_d     = state_q;
    laps_left_d = laps_left_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          if (laps == '0) begin
            state_d     = S_DONE;
            laps_left_d = '0;
          end else begin
            state_d     = S_CLEAR;
            laps_left_d = laps;
          end
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d     = S_IDLE;
          laps_left_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d     = S_IDLE;
          laps_left_d = '0;
        end else if (!hold_w && rco && (laps_left_q != '0)) begin
          laps_left_d = laps_left_q - LAP_W'(1);
          if (laps_left_q == LAP_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        laps_left_d = '0;
      end
      default: begin
        state_d     = S_IDLE;
        laps_left_d = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state (cnt_en also gated by hold).
  always_comb begin
    start_ready = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_CLEAR: cnt_clr = 1'b1;
      S_RUN:   cnt_en  = !hold_w;
      S_DONE:  done    = 1'b1;
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

  assign laps_left = laps_left_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - randomized self-checking bench for counter_seq_ctrl
// Optional feature macro: CNT_SEQ_HOLD_EN (connects and exercises hold).

module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] laps = 4'd0;
  logic       abort = 1'b0;
  logic       rco = 1'b0;
  logic       hold = 1'b0;
  logic       cnt_clr, cnt_en, busy, done;
  logic [3:0] laps_left;

  int checks = 0;
  int failures = 0;

  // Behavioural 4-bit counter datapath and schedule-level reference model.
  logic [3:0] cnt_q = 4'd0;
  bit         glitch = 1'b0;
  bit         m_busy = 1'b0;
  int         m_n = 0;
  int         m_t = 0;
  bit         obs_done, obs_en, obs_clr;

  counter_seq_ctrl #(.LAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .laps       (laps),
    .abort      (abort),
    .rco        (rco),
`ifdef CNT_SEQ_HOLD_EN
    .hold       (hold),
`endif
    .cnt_clr    (cnt_clr),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .done       (done),
    .laps_left  (laps_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: entered at negedge with inputs set, checks the DUT,
  // advances the model and the counter datapath, returns at the next negedge.
  task automatic step();
    bit eh, run, clr_e, en_e, done_e;
    int last_run, ll_e;
`ifdef CNT_SEQ_HOLD_EN
    eh = hold;
`else
    eh = 1'b0;
`endif
    last_run = 1 + 16 * m_n;
    clr_e  = m_busy && (m_n != 0) && (m_t == 1);
    run    = m_busy && (m_n != 0) && (m_t >= 2) && (m_t <= last_run);
    en_e   = run && !eh;
    done_e = m_busy && ((m_n == 0) ? (m_t == 1) : (m_t == last_run + 1));
    if (!m_busy)                    ll_e = 0;
    else if (m_t <= 1 && m_n != 0)  ll_e = m_n;
    else if (run)                   ll_e = m_n - (m_t - 2) / 16;
    else                            ll_e = 0;

    rco = (cnt_q == 4'hF) || (glitch && !en_e);
    #1;
    check("start_ready", int'(start_ready), int'(!m_busy));
    check("busy",        int'(busy),        int'(m_busy));
    check("cnt_clr",     int'(cnt_clr),     int'(clr_e));
    check("cnt_en",      int'(cnt_en),      int'(en_e));
    check("done",        int'(done),        int'(done_e));
    check("laps_left",   int'(laps_left),   ll_e);
    obs_done = done;
    obs_en   = cnt_en;
    obs_clr  = cnt_clr;

    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (start_valid) begin
        m_busy = 1'b1;
        m_n    = int'(laps);
        m_t    = 1;
      end
    end else if ((clr_e || run) && abort) begin
      m_busy = 1'b0;
    end else if (done_e) begin
      m_busy = 1'b0;
    end else if (!(run && eh)) begin
      m_t++;
    end

    @(posedge clk);
    if (obs_clr)     cnt_q = 4'd0;
    else if (obs_en) cnt_q = cnt_q + 4'd1;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      start_valid = 1'b0;
      abort  = ($urandom_range(0, 1) == 0);
      glitch = ($urandom_range(0, 1) == 0);
      hold   = ($urandom_range(0, 1) == 0);
      step();
    end
    abort = 1'b0;
    hold  = 1'b0;
  endtask

  // Issue one command at relative cycle 0 and run until the model is idle again.
  task automatic run_cmd(input int n, input int abort_at, input int hold_from,
                         input int hold_to, input int rst_at, input bit keep_valid,
                         output int done_cyc, output int en_cnt, output int clr_cnt);
    bit ended = 1'b0;
    done_cyc = -1;
    en_cnt   = 0;
    clr_cnt  = 0;
    for (int c = 0; c < 400; c++) begin
      start_valid = (c == 0) || keep_valid;
      laps   = 4'(n);
      abort  = (c == abort_at);
      rst    = (c == rst_at);
      hold   = (c >= hold_from) && (c <= hold_to);
      glitch = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
      step();
      if (obs_done) done_cyc = c;
      en_cnt  += int'(obs_en);
      clr_cnt += int'(obs_clr);
      if (!m_busy) begin
        ended = 1'b1;
        break;
      end
    end
    start_valid = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    hold  = 1'b0;
    glitch = 1'b0;
    if (!ended) check("run_timeout", 0, 1);
  endtask

  initial begin
    int dc, ec, cc, n, ab, hf, hl, ra, exp_hold_done;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(6);

    // Single lap.
    run_cmd(1, -1, -1, -1, -1, 1'b0, dc, ec, cc);
    check("lap1_done_cyc", dc, 18);
    check("lap1_en_cnt", ec, 16);
    check("lap1_clr_cnt", cc, 1);
    check("lap1_cnt_end", int'(cnt_q), 0);
    idle_cycles(1);

    // Three laps.
    run_cmd(3, -1, -1, -1, -1, 1'b0, dc, ec, cc);
    check("lap3_done_cyc", dc, 50);
    check("lap3_en_cnt", ec, 48);
    check("lap3_cnt_end", int'(cnt_q), 0);

    // Zero laps.
    run_cmd(0, -1, -1, -1, -1, 1'b0, dc, ec, cc);
    check("lap0_done_cyc", dc, 1);
    check("lap0_en_cnt", ec, 0);
    check("lap0_clr_cnt", cc, 0);

    // start_valid held through a two-lap run, then a fresh command right away.
    run_cmd(2, -1, -1, -1, -1, 1'b1, dc, ec, cc);
    check("bp_done_cyc", dc, 34);
    run_cmd(1, -1, -1, -1, -1, 1'b0, dc, ec, cc);
    check("bp_next_done_cyc", dc, 18);

    // Abort coinciding with the first rco; new command in the following cycle.
    run_cmd(2, 17, -1, -1, -1, 1'b0, dc, ec, cc);
    check("abort_no_done", dc, -1);
    check("abort_en_cnt", ec, 16);
    run_cmd(1, -1, -1, -1, -1, 1'b0, dc, ec, cc);
    check("after_abort_done_cyc", dc, 18);
    check("after_abort_cnt_end", int'(cnt_q), 0);

    // Hold cycles 5..9 with rco glitches during the hold.
`ifdef CNT_SEQ_HOLD_EN
    exp_hold_done = 23;
`else
    exp_hold_done = 18;
`endif
    run_cmd(1, -1, 5, 9, -1, 1'b0, dc, ec, cc);
    check("hold_done_cyc", dc, exp_hold_done);
    check("hold_en_cnt", ec, 16);

    // Reset in the middle of a run.
    run_cmd(2, -1, -1, -1, 10, 1'b0, dc, ec, cc);
    check("rst_no_done", dc, -1);
    idle_cycles(2);

    // Randomized commands with random abort, hold and reset.
    for (int i = 0; i < 25; i++) begin
      n  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 + 16 * n)) : -1;
      hf = int'($urandom_range(2, 30));
      hl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : -1;
      ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_cmd(n, ab, hf, hf + hl, ra, ($urandom_range(0, 3) == 0), dc, ec, cc);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
